// File: rtl/ctrl_pipe_if.sv
// Control bundle between the ID-stage decoder and the pipeline control block.
// The decoder side (master) drives the decoded ID controls and specifiers;
// the pipeline side (slave) returns staged controls, forwarding selects and
// hazard handshakes.
interface ctrl_pipe_if #(
  parameter int REG_W = 5,
  parameter int ALU_W = 3
);
  logic             mem_to_reg_d;
  logic             mem_enab_d;
  logic             alu_srcB_d;
  logic             reg_dst_d;
  logic             reg_write_d;
  logic [ALU_W-1:0] alu_ctrl_sig_d;
  logic [REG_W-1:0] rs_d;
  logic [REG_W-1:0] rt_d;
  logic [REG_W-1:0] rd_d;
  logic             pc_src_d;

  logic [ALU_W-1:0] alu_ctrl_sig_e;
  logic             alu_srcB_e;
  logic [REG_W-1:0] rs_e;
  logic [REG_W-1:0] rt_e;
  logic [REG_W-1:0] write_reg_e;
  logic [1:0]       fwd_a_e;
  logic [1:0]       fwd_b_e;
  logic             mem_enab_m;
  logic             mem_to_reg_m;
  logic             reg_write_m;
  logic [REG_W-1:0] write_reg_m;
  logic             mem_to_reg_w;
  logic             reg_write_w;
  logic [REG_W-1:0] write_reg_w;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;

  modport master (
    output mem_to_reg_d, mem_enab_d, alu_srcB_d, reg_dst_d, reg_write_d,
           alu_ctrl_sig_d, rs_d, rt_d, rd_d, pc_src_d,
    input  alu_ctrl_sig_e, alu_srcB_e, rs_e, rt_e, write_reg_e, fwd_a_e, fwd_b_e,
           mem_enab_m, mem_to_reg_m, reg_write_m, write_reg_m,
           mem_to_reg_w, reg_write_w, write_reg_w, stall_f, stall_d, flush_d
  );

  modport slave (
    input  mem_to_reg_d, mem_enab_d, alu_srcB_d, reg_dst_d, reg_write_d,
           alu_ctrl_sig_d, rs_d, rt_d, rd_d, pc_src_d,
    output alu_ctrl_sig_e, alu_srcB_e, rs_e, rt_e, write_reg_e, fwd_a_e, fwd_b_e,
           mem_enab_m, mem_to_reg_m, reg_write_m, write_reg_m,
           mem_to_reg_w, reg_write_w, write_reg_w, stall_f, stall_d, flush_d
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Pipeline control carrier: moves decoded controls through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards (stall + bubble), arbitrates branch flush
// against stall, and produces EX-stage forwarding selects.
module ctrl_pipe #(
  parameter int REG_W = 5,
  parameter int ALU_W = 3
) (
  input  logic         clk,
  input  logic         reset,
  ctrl_pipe_if.slave   bus
);

  logic             mem_to_reg_e, mem_enab_e, alu_srcB_e, reg_dst_e, reg_write_e;
  logic [ALU_W-1:0] alu_ctrl_e;
  logic [REG_W-1:0] rs_e, rt_e, rd_e;
  logic [REG_W-1:0] write_reg_e;

  logic             mem_enab_m, mem_to_reg_m, reg_write_m;
  logic [REG_W-1:0] write_reg_m;

  logic             mem_to_reg_w, reg_write_w;
  logic [REG_W-1:0] write_reg_w;

  logic             lwstall;
  logic             flush;
  logic [1:0]       fwd_a, fwd_b;

  assign write_reg_e = reg_dst_e ? rd_e : rt_e;

  // Load-use detection and branch flush; reset masks both so the handshakes
  // read idle while the pipe is being cleared.
  always_comb begin
    lwstall = 1'b0;
    flush   = 1'b0;
    if (!reset) begin
      lwstall = mem_to_reg_e & reg_write_e & (rt_e != '0) &
                ((rt_e == bus.rs_d) | (rt_e == bus.rt_d));
      flush   = bus.pc_src_d & ~lwstall;
    end
  end

  // ID/EX register: a load-use stall inserts a bubble instead of the ID values.
  always_ff @(posedge clk) begin
    if (reset || lwstall) begin
      mem_to_reg_e <= 1'b0;
      mem_enab_e   <= 1'b0;
      alu_srcB_e   <= 1'b0;
      reg_dst_e    <= 1'b0;
      reg_write_e  <= 1'b0;
      alu_ctrl_e   <= '0;
      rs_e         <= '0;
      rt_e         <= '0;
      rd_e         <= '0;
    end else begin
      mem_to_reg_e <= bus.mem_to_reg_d;
      mem_enab_e   <= bus.mem_enab_d;
      alu_srcB_e   <= bus.alu_srcB_d;
      reg_dst_e    <= bus.reg_dst_d;
      reg_write_e  <= bus.reg_write_d;
      alu_ctrl_e   <= bus.alu_ctrl_sig_d;
      rs_e         <= bus.rs_d;
      rt_e         <= bus.rt_d;
      rd_e         <= bus.rd_d;
    end
  end

  // EX/MEM and MEM/WB registers always advance, even during a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_enab_m   <= 1'b0;
      mem_to_reg_m <= 1'b0;
      reg_write_m  <= 1'b0;
      write_reg_m  <= '0;
      mem_to_reg_w <= 1'b0;
      reg_write_w  <= 1'b0;
      write_reg_w  <= '0;
    end else begin
      mem_enab_m   <= mem_enab_e;
      mem_to_reg_m <= mem_to_reg_e;
      reg_write_m  <= reg_write_e;
      write_reg_m  <= write_reg_e;
      mem_to_reg_w <= mem_to_reg_m;
      reg_write_w  <= reg_write_m;
      write_reg_w  <= write_reg_m;
    end
  end

  // Forwarding selects: MEM result wins over WB; r0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (reg_write_m && (write_reg_m != '0) && (write_reg_m == rs_e))
      fwd_a = 2'b10;
    else if (reg_write_w && (write_reg_w != '0) && (write_reg_w == rs_e))
      fwd_a = 2'b01;
    if (reg_write_m && (write_reg_m != '0) && (write_reg_m == rt_e))
      fwd_b = 2'b10;
    else if (reg_write_w && (write_reg_w != '0) && (write_reg_w == rt_e))
      fwd_b = 2'b01;
  end

  assign bus.alu_ctrl_sig_e = alu_ctrl_e;
  assign bus.alu_srcB_e     = alu_srcB_e;
  assign bus.rs_e           = rs_e;
  assign bus.rt_e           = rt_e;
  assign bus.write_reg_e    = write_reg_e;
  assign bus.fwd_a_e        = fwd_a;
  assign bus.fwd_b_e        = fwd_b;
  assign bus.mem_enab_m     = mem_enab_m;
  assign bus.mem_to_reg_m   = mem_to_reg_m;
  assign bus.reg_write_m    = reg_write_m;
  assign bus.write_reg_m    = write_reg_m;
  assign bus.mem_to_reg_w   = mem_to_reg_w;
  assign bus.reg_write_w    = reg_write_w;
  assign bus.write_reg_w    = write_reg_w;
  assign bus.stall_f        = lwstall;
  assign bus.stall_d        = lwstall;
  assign bus.flush_d        = flush;

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumes the decoded control bundle from the ID-stage controller and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers, together with the register specifiers.
- Generates load-use stall/flush and EX-stage forwarding selects for the pipelined datapath.
- It is the receiving end of the controller's output interface: decode produces control, this block delivers it stage by stage and keeps it hazard-safe.

Parameters:
- REG_W, 5, register specifier width
- ALU_W, 3, ALU control width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- mem_to_reg_d  in  1  decoded load select
- mem_enab_d  in  1  decoded store enable
- alu_srcB_d  in  1  decoded ALU B-source select
- reg_dst_d  in  1  1 selects rd as destination, 0 selects rt
- reg_write_d  in  1  decoded register write
- alu_ctrl_sig_d  in  ALU_W  decoded ALU op
- rs_d, rt_d, rd_d  in  REG_W each  ID-stage specifiers
- pc_src_d  in  1  branch/jump taken, resolved in ID
- alu_ctrl_sig_e  out  ALU_W  EX ALU op
- alu_srcB_e  out  1  EX B-source select
- rs_e, rt_e  out  REG_W  EX specifiers
- write_reg_e  out  REG_W  EX destination (combinational mux)
- fwd_a_e, fwd_b_e  out  2  00 regfile, 10 from MEM, 01 from WB
- mem_enab_m, mem_to_reg_m, reg_write_m  out  1 each  MEM controls
- write_reg_m  out  REG_W  MEM destination
- mem_to_reg_w, reg_write_w  out  1 each  WB controls
- write_reg_w  out  REG_W  WB destination
- stall_f, stall_d  out  1 each  hold PC and IF/ID
- flush_d  out  1  clear IF/ID

Behaviour:
- Reset (synchronous): every registered output becomes 0. All stages hold a bubble; forwarding selects are 00; stall and flush are 0.
- Each stage register advances by one stage per cycle. A control value applied in ID appears in EX 1 cycle later, in MEM 2 cycles later, and in WB 3 cycles later.
- Destination select: write_reg_e = reg_dst_e ? rd_e : rt_e. This is combinational from the ID/EX register. write_reg_m and write_reg_w are registered copies.
- Load-use hazard: lwstall = mem_to_reg_e & reg_write_e & (rt_e != 0) & ((rt_e == rs_d) | (rt_e == rt_d)).
  - stall_f = stall_d = lwstall, combinational.
  - On lwstall the ID/EX register loads a bubble (all controls and specifiers 0) instead of the ID values.
  - EX/MEM and MEM/WB still advance.
- Branch: flush_d = pc_src_d & ~lwstall. A stall has priority, so the branch is re-evaluated in the next cycle. pc_src_d does not bubble EX.
- Forwarding A (B is identical, using rt_e):
  - 10 if reg_write_m & (write_reg_m != 0) & (write_reg_m == rs_e);
  - else 01 if reg_write_w & (write_reg_w != 0) & (write_reg_w == rs_e);
  - else 00.
  - MEM has priority over WB when both match. Register 0 never forwards.
- A bubble never writes and never matches: reg_write = 0 in that stage.
- Back-to-back loads each cause one stall cycle only.
- Reset asserted mid-stall overrides everything: the next cycle shows all zeros.

Test Plan:
- Reset: assert reset for 2 cycles with non-zero decoded inputs -> all outputs 0. After release, reg_write_d=1, reg_dst_d=1, rd_d=7 -> write_reg_e=7 after 1 cycle, write_reg_m=7 after 2, reg_write_w=1 and write_reg_w=7 after 3.
- Load-use: lw with rt=5, next instruction has rs_d=5 -> stall_f=stall_d=1 for exactly 1 cycle. EX shows a bubble (reg_write_e path 0). The dependent op then reaches EX with fwd_a_e=01.
- Forward priority: writes to r3 in MEM and in WB, EX reads rs_e=3 and rt_e=3 -> fwd_a_e=fwd_b_e=10. Once only WB matches -> 01.
- Register zero: reg_write_m=1, write_reg_m=0, rs_e=0 -> fwd_a_e=00. lw with rt=0 followed by a reader of r0 -> no stall.
- Branch vs stall: pc_src_d=1 together with lwstall=1 -> flush_d=0, stall=1. The next cycle has pc_src_d=1 and no hazard -> flush_d=1.
- Reset during stall: lwstall active when reset rises -> the following cycle shows stall_f=0 and all stage outputs 0.
